// File: rtl/ext_irq_source_pkg.sv
// ext_irq_source_pkg: shared constants for the external interrupt source.
`default_nettype none

package ext_irq_source_pkg;

  localparam int N_IRQ_DEFAULT    = 16;
  localparam int MCA_BASE_DEFAULT = 7;
  localparam int MCA_WIDTH        = 23;

  localparam logic [1:0] SEL_MASK = 2'd0;
  localparam logic [1:0] SEL_EDGE = 2'd1;
  localparam logic [1:0] SEL_PEND = 2'd2;
  localparam logic [1:0] SEL_OVR  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/ext_irq_source_line_cell.sv
// irq_line_cell: one interrupt line -- synchronizer, rise detect, pending/overrun flags, ack pulse.
`default_nettype none

module irq_line_cell (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  input  logic edge_mode,
  input  logic mask,
  input  logic ackv,
  input  logic pend_clr,
  input  logic ovr_clr,
  input  logic mode_drop,
  output logic pending,
  output logic overrun,
  output logic cause,
  output logic irq_ack
);

  logic sync1, sync2, sync3;
  logic rise;
  logic clr_any;
  logic pending_next;
  logic overrun_next;

  assign rise    = sync2 & ~sync3;
  assign clr_any = (edge_mode & ackv) | pend_clr;

  // A rise outranks ack/W1C so no edge is lost; leaving edge mode wins over everything.
  always_comb begin
    pending_next = pending;
    overrun_next = overrun;
    if (mode_drop) begin
      pending_next = 1'b0;
    end else if (edge_mode && rise) begin
      pending_next = 1'b1;
    end else if (clr_any) begin
      pending_next = 1'b0;
    end
    if (ovr_clr) begin
      overrun_next = 1'b0;
    end
    // A rise into an occurrence that is being consumed this cycle is not an overrun.
    if (!mode_drop && edge_mode && rise && pending && !clr_any) begin
      overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      pending <= 1'b0;
      overrun <= 1'b0;
      irq_ack <= 1'b0;
    end else begin
      sync1   <= irq_in;
      sync2   <= sync1;
      sync3   <= sync2;
      pending <= pending_next;
      overrun <= overrun_next;
      irq_ack <= ackv;
    end
  end

  assign cause = (edge_mode ? pending : sync2) & mask;

endmodule

`default_nettype wire

// File: rtl/ext_irq_source.sv
// ext_irq_source: collects device interrupt lines into ca[22:7] and acknowledges serviced lines.
`default_nettype none

module ext_irq_source
  import ext_irq_source_pkg::*;
#(
  parameter int N_IRQ    = N_IRQ_DEFAULT,
  parameter int MCA_BASE = MCA_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IRQ-1:0]     irq_in,
  input  logic                 jisr,
  input  logic [MCA_WIDTH-1:0] mca,
  input  logic                 wr_en,
  input  logic [1:0]           reg_sel,
  input  logic [N_IRQ-1:0]     wr_data,
  output logic [N_IRQ-1:0]     rd_data,
  output logic [N_IRQ-1:0]     ca_part_1,
  output logic [N_IRQ-1:0]     irq_ack
);

  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] edge_mode;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] overrun;
  logic [N_IRQ-1:0] ackv;
  logic [N_IRQ-1:0] pend_clr;
  logic [N_IRQ-1:0] ovr_clr;
  logic [N_IRQ-1:0] mode_drop;
  logic             unused_mca;

  // Only the external slice of mca is consumed; the rest belongs to other sources.
  assign unused_mca = ^mca;
  assign ackv       = {N_IRQ{jisr}} & mca[MCA_BASE +: N_IRQ];
  assign pend_clr   = (wr_en && reg_sel == SEL_PEND) ? wr_data : '0;
  assign ovr_clr    = (wr_en && reg_sel == SEL_OVR)  ? wr_data : '0;
  assign mode_drop  = (wr_en && reg_sel == SEL_EDGE) ? (edge_mode & ~wr_data) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask      <= '0;
      edge_mode <= '0;
    end else if (wr_en) begin
      if (reg_sel == SEL_MASK) mask      <= wr_data;
      if (reg_sel == SEL_EDGE) edge_mode <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      SEL_MASK: rd_data = mask;
      SEL_EDGE: rd_data = edge_mode;
      SEL_PEND: rd_data = pending;
      SEL_OVR:  rd_data = overrun;
      default:  rd_data = '0;
    endcase
  end

  for (genvar i = 0; i < N_IRQ; i++) begin : g_line
    irq_line_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .irq_in    (irq_in[i]),
      .edge_mode (edge_mode[i]),
      .mask      (mask[i]),
      .ackv      (ackv[i]),
      .pend_clr  (pend_clr[i]),
      .ovr_clr   (ovr_clr[i]),
      .mode_drop (mode_drop[i]),
      .pending   (pending[i]),
      .overrun   (overrun[i]),
      .cause     (ca_part_1[i]),
      .irq_ack   (irq_ack[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_ext_irq_source.sv
// tb_ext_irq_source: directed self-checking bench for ext_irq_source.
`default_nettype none

module tb_ext_irq_source;

  logic        clk;
  logic        rst;
  logic [15:0] irq_in;
  logic        jisr;
  logic [22:0] mca;
  logic        wr_en;
  logic [1:0]  reg_sel;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic [15:0] ca_part_1;
  logic [15:0] irq_ack;

  int tests;
  int fails;

  ext_irq_source dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .jisr      (jisr),
    .mca       (mca),
    .wr_en     (wr_en),
    .reg_sel   (reg_sel),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .ca_part_1 (ca_part_1),
    .irq_ack   (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [15:0] data);
    wr_en   = 1'b1;
    reg_sel = sel;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
    wr_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    irq_in = '0; jisr = 1'b0; mca = '0; wr_en = 1'b0; reg_sel = 2'd0; wr_data = '0;
    tick(2);
    rst = 1'b1;
    tick();
    tests++;
    if (ca_part_1 !== 16'h0000) begin
      fails++; $display("FAIL reset_ca actual=%h required=%h", ca_part_1, 16'h0000);
    end
    tests++;
    if (irq_ack !== 16'h0000) begin
      fails++; $display("FAIL reset_ack actual=%h required=%h", irq_ack, 16'h0000);
    end
    for (int s = 0; s < 4; s++) begin
      reg_sel = 2'(s);
      #1;
      tests++;
      if (rd_data !== 16'h0000) begin
        fails++; $display("FAIL reset_reg%0d actual=%h required=%h", s, rd_data, 16'h0000);
      end
    end
  endtask

  task automatic test_level();
    write_reg(2'd0, 16'hFFFF);
    write_reg(2'd1, 16'h0000);
    irq_in = 16'h0008;
    tick();
    tests++;
    if (ca_part_1 !== 16'h0000) begin
      fails++; $display("FAIL level_edge1 actual=%h required=%h", ca_part_1, 16'h0000);
    end
    tick();
    tests++;
    if (ca_part_1 !== 16'h0008) begin
      fails++; $display("FAIL level_edge2 actual=%h required=%h", ca_part_1, 16'h0008);
    end
    reg_sel = 2'd2;
    #1;
    tests++;
    if (rd_data !== 16'h0000) begin
      fails++; $display("FAIL level_no_pending actual=%h required=%h", rd_data, 16'h0000);
    end
    irq_in = '0;
    tick();
    tests++;
    if (ca_part_1 !== 16'h0008) begin
      fails++; $display("FAIL level_fall1 actual=%h required=%h", ca_part_1, 16'h0008);
    end
    tick();
    tests++;
    if (ca_part_1 !== 16'h0000) begin
      fails++; $display("FAIL level_fall2 actual=%h required=%h", ca_part_1, 16'h0000);
    end
  endtask

  task automatic test_edge_ack();
    write_reg(2'd1, 16'h0001);
    write_reg(2'd0, 16'h0001);
    irq_in = 16'h0001;
    tick();
    irq_in = '0;
    tick();
    tests++;
    if (ca_part_1 !== 16'h0000) begin
      fails++; $display("FAIL edge_early actual=%h required=%h", ca_part_1, 16'h0000);
    end
    tick();
    tests++;
    if (ca_part_1 !== 16'h0001) begin
      fails++; $display("FAIL edge_edge3 actual=%h required=%h", ca_part_1, 16'h0001);
    end
    tick(3);
    tests++;
    if (ca_part_1 !== 16'h0001) begin
      fails++; $display("FAIL edge_held actual=%h required=%h", ca_part_1, 16'h0001);
    end
    jisr = 1'b1;
    mca  = 23'h1 << 7;
    tick();
    jisr = 1'b0;
    mca  = '0;
    reg_sel = 2'd2;
    #1;
    tests++;
    if (rd_data !== 16'h0000) begin
      fails++; $display("FAIL ack_pending_clr actual=%h required=%h", rd_data, 16'h0000);
    end
    tests++;
    if (irq_ack !== 16'h0001) begin
      fails++; $display("FAIL ack_pulse actual=%h required=%h", irq_ack, 16'h0001);
    end
    tests++;
    if (ca_part_1 !== 16'h0000) begin
      fails++; $display("FAIL ack_ca_drop actual=%h required=%h", ca_part_1, 16'h0000);
    end
    tick();
    tests++;
    if (irq_ack !== 16'h0000) begin
      fails++; $display("FAIL ack_one_cycle actual=%h required=%h", irq_ack, 16'h0000);
    end
  endtask

  task automatic test_masked_pending();
    write_reg(2'd0, 16'h0000);
    write_reg(2'd1, 16'h0020);
    irq_in = 16'h0020;
    tick();
    irq_in = '0;
    tick(4);
    reg_sel = 2'd2;
    #1;
    tests++;
    if (rd_data !== 16'h0020) begin
      fails++; $display("FAIL masked_pending actual=%h required=%h", rd_data, 16'h0020);
    end
    tests++;
    if (ca_part_1 !== 16'h0000) begin
      fails++; $display("FAIL masked_ca actual=%h required=%h", ca_part_1, 16'h0000);
    end
    write_reg(2'd0, 16'h0020);
    tests++;
    if (ca_part_1 !== 16'h0020) begin
      fails++; $display("FAIL unmask_ca actual=%h required=%h", ca_part_1, 16'h0020);
    end
    write_reg(2'd2, 16'h0020);
    reg_sel = 2'd2;
    #1;
    tests++;
    if (rd_data !== 16'h0000) begin
      fails++; $display("FAIL w1c_pending actual=%h required=%h", rd_data, 16'h0000);
    end
  endtask

  task automatic test_overrun();
    write_reg(2'd1, 16'h0004);
    write_reg(2'd0, 16'h0004);
    for (int p = 0; p < 2; p++) begin
      irq_in = 16'h0004;
      tick();
      irq_in = '0;
      tick(4);
    end
    reg_sel = 2'd3;
    #1;
    tests++;
    if (rd_data !== 16'h0004) begin
      fails++; $display("FAIL overrun_set actual=%h required=%h", rd_data, 16'h0004);
    end
    write_reg(2'd3, 16'h0004);
    reg_sel = 2'd3;
    #1;
    tests++;
    if (rd_data !== 16'h0000) begin
      fails++; $display("FAIL overrun_w1c actual=%h required=%h", rd_data, 16'h0000);
    end
    reg_sel = 2'd2;
    #1;
    tests++;
    if (rd_data !== 16'h0004) begin
      fails++; $display("FAIL overrun_pending_kept actual=%h required=%h", rd_data, 16'h0004);
    end
    write_reg(2'd2, 16'h0004);
  endtask

  task automatic test_back_to_back();
    write_reg(2'd1, 16'h0002);
    write_reg(2'd0, 16'h0002);
    irq_in = 16'h0002;
    tick();
    irq_in = '0;
    tick(4);
    // Second pulse: rise is seen during the cycle after its 2nd edge; ack lands on the same edge.
    irq_in = 16'h0002;
    tick();
    irq_in = '0;
    tick();
    jisr = 1'b1;
    mca  = 23'h1 << 8;
    tick();
    jisr = 1'b0;
    mca  = '0;
    reg_sel = 2'd2;
    #1;
    tests++;
    if (rd_data !== 16'h0002) begin
      fails++; $display("FAIL b2b_pending actual=%h required=%h", rd_data, 16'h0002);
    end
    reg_sel = 2'd3;
    #1;
    tests++;
    if (rd_data !== 16'h0000) begin
      fails++; $display("FAIL b2b_no_overrun actual=%h required=%h", rd_data, 16'h0000);
    end
    tests++;
    if (irq_ack !== 16'h0002) begin
      fails++; $display("FAIL b2b_ack actual=%h required=%h", irq_ack, 16'h0002);
    end
    write_reg(2'd1, 16'h0000);
    reg_sel = 2'd2;
    #1;
    tests++;
    if (rd_data !== 16'h0000) begin
      fails++; $display("FAIL mode_drop_clears actual=%h required=%h", rd_data, 16'h0000);
    end
  endtask

  task automatic test_async_reset();
    write_reg(2'd1, 16'h0001);
    write_reg(2'd0, 16'h0001);
    irq_in = 16'h0001;
    tick();
    irq_in = '0;
    tick(4);
    tests++;
    if (ca_part_1 !== 16'h0001) begin
      fails++; $display("FAIL prereset_ca actual=%h required=%h", ca_part_1, 16'h0001);
    end
    jisr = 1'b1;
    mca  = 23'h1 << 11;
    tick();
    jisr = 1'b0;
    mca  = '0;
    tests++;
    if (irq_ack !== 16'h0010) begin
      fails++; $display("FAIL prereset_ack actual=%h required=%h", irq_ack, 16'h0010);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (ca_part_1 !== 16'h0000) begin
      fails++; $display("FAIL areset_ca actual=%h required=%h", ca_part_1, 16'h0000);
    end
    tests++;
    if (irq_ack !== 16'h0000) begin
      fails++; $display("FAIL areset_ack actual=%h required=%h", irq_ack, 16'h0000);
    end
    for (int s = 0; s < 4; s++) begin
      reg_sel = 2'(s);
      #0.5;
      tests++;
      if (rd_data !== 16'h0000) begin
        fails++; $display("FAIL areset_reg%0d actual=%h required=%h", s, rd_data, 16'h0000);
      end
    end
    tick();
    rst = 1'b1;
    write_reg(2'd1, 16'hFFFF);
    write_reg(2'd0, 16'hFFFF);
    tick(4);
    reg_sel = 2'd2;
    #1;
    tests++;
    if (rd_data !== 16'h0000) begin
      fails++; $display("FAIL postreset_pending actual=%h required=%h", rd_data, 16'h0000);
    end
    tests++;
    if (ca_part_1 !== 16'h0000) begin
      fails++; $display("FAIL postreset_ca actual=%h required=%h", ca_part_1, 16'h0000);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_level();
    test_edge_ack();
    test_masked_pending();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ext_irq_source.md
Name: ext_irq_source

Overview:
- Initiator side of the external-interrupt path: collects asynchronous device interrupt lines and drives ca_part_1, the 16 external cause bits at ca[22:7], into the interrupt unit.
- Consumes that unit's jisr/mca to acknowledge serviced lines back to the devices.
- Provides mask, edge/level mode, pending and overrun registers, accessible through a small SPR-style read/write port.

Parameters:
- N_IRQ, 16, number of external lines; equals the ca_part_1 width.
- MCA_BASE, 7, bit index in mca of line 0; line i maps to mca[MCA_BASE+i].

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- irq_in  input  N_IRQ  raw device interrupt lines, asynchronous to clk.
- jisr  input  1  jump-to-ISR strobe from the interrupt unit.
- mca  input  23  masked cause vector from the interrupt unit.
- wr_en  input  1  register write strobe.
- reg_sel  input  2  register select: 0 mask, 1 edge_mode, 2 pending, 3 overrun.
- wr_data  input  N_IRQ  write data.
- rd_data  output  N_IRQ  combinational readback of the reg_sel register.
- ca_part_1  output  N_IRQ  external cause bits to the interrupt unit.
- irq_ack  output  N_IRQ  one-cycle acknowledge pulse per line.

Behaviour:
- Reset (rst=0, asynchronous): sync1, sync2 and sync3 = 0; mask = 0; edge_mode = 0 (level); pending = 0; overrun = 0; irq_ack = 0. As a result, ca_part_1 = 0 and rd_data reflects the zeroed registers.
- Synchronizer, per line: sync1 <= irq_in, sync2 <= sync1, sync3 <= sync2. rise = sync2 & ~sync3.
- Level mode (edge_mode[i]=0):
  - ca_part_1[i] = sync2[i] & mask[i].
  - Visible after the 2nd rising clk edge with irq_in high.
  - pending[i] is not set.
- Edge mode (edge_mode[i]=1):
  - pending[i] <= 1 on rise[i].
  - ca_part_1[i] = pending[i] & mask[i].
  - Visible after the 3rd rising edge.
- A rise is recorded in pending even while masked. Unmasking later raises ca_part_1 immediately in the same cycle, combinationally.
- Overrun: rise[i] while pending[i] is already 1 sets overrun[i]. Overrun is sticky until cleared by software.
- Ack:
  - ackv[i] = jisr & mca[MCA_BASE+i].
  - irq_ack[i] <= ackv[i], a registered pulse lasting exactly 1 cycle, issued for both modes.
  - In edge mode ackv clears pending[i] on that edge.
- Register writes (on the clk edge with wr_en=1):
  - sel 0 and sel 1: full overwrite of mask / edge_mode.
  - sel 2 and sel 3: write-1-to-clear of pending / overrun.
- Simultaneous events in one cycle, resolved in priority order:
  1. rise beats ack-clear and W1C-clear, so pending stays 1 and no edge is lost.
  2. rise with pending=1 and a clear in the same cycle keeps pending=1 and does not set overrun, since the old occurrence is consumed.
  3. ack and W1C on the same bit both clear it.
- Changing edge_mode[i] from 1 to 0 clears pending[i] on that edge. Changing it from 0 to 1 does not synthesize a rise.
- Reset mid-operation: all state is dropped immediately, and an in-flight irq_ack is cancelled.
- No multi-cycle handshake toward the interrupt unit. The cause level is held until ack or clear.

Decomposition:
- Shared package holds:
  - register select constants: SEL_MASK=0, SEL_EDGE=1, SEL_PEND=2, SEL_OVR=3;
  - the MCA_BASE default;
  - N_IRQ default 16.
- One natural sub-module: irq_line_cell, one line containing its synchronizer, edge detect, pending/overrun flops and ack flop, generated N_IRQ times. The top level holds the mask/edge_mode registers and the readback mux.

Test Plan:
- Reset, then write mask=16'hFFFF (sel 0), edge_mode=16'h0000. Raise irq_in[3]. Required: ca_part_1=16'h0008 after exactly 2 clk edges; it drops 2 edges after irq_in[3] falls.
- edge_mode=16'h0001, mask=16'h0001, pulse irq_in[0] for 1 cycle. Required: ca_part_1[0]=1 after the 3rd edge and held. Then drive jisr=1 with mca[7]=1 for one cycle. Required: pending[0]=0 after that edge, and irq_ack=16'h0001 for exactly one cycle.
- Edge mode, mask=0, pulse irq_in[5] (edge_mode[5]=1). Required: rd_data(sel 2)=16'h0020 and ca_part_1=0. Write mask=16'h0020. Required: ca_part_1=16'h0020 in the same cycle as the write takes effect.
- Two pulses on irq_in[2] (edge mode) with no ack between them. Required: overrun(sel 3)=16'h0004. Write sel 3 with 16'h0004. Required: overrun=0, pending still 1.
- rise on line 1 in the same cycle as jisr with mca[8]=1 and pending[1]=1. Required: pending[1] stays 1, overrun[1]=0, irq_ack[1] pulses.
- Assert rst=0 mid-pending, asynchronously between edges. Required: ca_part_1, irq_ack and all registers read 0 immediately; after release, no spurious rise is detected when irq_in is held at 0.
